seq_det_event_logger: RTL and testbench

SEQ_DET_EVENT_LOGGER -- requirements
Module: seq_det_event_logger

---
 rtl/seq_det_event_logger_pkg.sv | 16 +
 rtl/seq_det_event_logger_if.sv | 23 ++
 rtl/seq_det_event_logger_ts_fifo.sv | 76 +++++++
 rtl/seq_det_event_logger.sv | 79 +++++++
 tb/tb_seq_det_event_logger.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_event_logger_pkg.sv
// Shared constants for the 10X0 sequence-detector event logger and the
// detector bench that drives it.
package seq_det_pkg;

    // Default geometry of the logger.
    localparam int DEF_DEPTH = 4;   // timestamp FIFO entries (power of 2, 2..16)
    localparam int DEF_TS_W  = 8;   // timestamp width
    localparam int DEF_CNT_W = 8;   // saturating event counter width

    // FIFO pointer width: one extra bit beyond the address so that full
    // and empty can be told apart when the address bits are equal.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/seq_det_event_logger_if.sv
// Read-side handshake of the event logger: the logger (master) presents the
// oldest timestamp, the consumer (slave) accepts it with rd_ready.
interface seq_det_event_logger_if
    import seq_det_pkg::*;
#(
    parameter int TS_W = DEF_TS_W
);
    logic            rd_valid;
    logic            rd_ready;
    logic [TS_W-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/seq_det_event_logger_ts_fifo.sv
// Synchronous timestamp FIFO with a registered head output. A write becomes
// visible on dout one cycle later; dout holds its value while the FIFO is
// empty. A push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle.
module ts_fifo
    import seq_det_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = DEF_TS_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0] wr_ptr_next, rd_ptr_next;
    logic [W-1:0]  dout_reg, dout_next;
    logic          push_ok, pop_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A flush discards any push or pop requested in the same cycle.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);

    // Next pointers and the value the head register should show next cycle.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + PW'(push_ok);
        rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
        dout_next   = dout_reg;
        if (!flush && (wr_ptr_next != rd_ptr_next)) begin
            // The new head may be the slot being written right now.
            if (push_ok && (rd_ptr_next == wr_ptr_reg))
                dout_next = din;
            else
                dout_next = mem[rd_ptr_next[AW-1:0]];
        end
    end

    // Storage array; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    // Pointer and head-register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            dout_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            dout_reg   <= dout_reg;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            dout_reg   <= dout_next;
        end
    end

    assign dout = dout_reg;
endmodule

// File: rtl/seq_det_event_logger.sv
// Event logger for a Moore 10X0 sequence detector: counts rising edges of
// the detector output, timestamps each one into a small FIFO, and flags
// detections lost because the FIFO was full.
module seq_det_event_logger
    import seq_det_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TS_W  = DEF_TS_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    det_in,
    input  logic                    clr,
    seq_det_event_logger_if.master  bus,
    output logic [CNT_W-1:0]        evt_count,
    output logic                    overflow
);
    logic              det_q_reg;
    logic [TS_W-1:0]   ts_reg;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ovf_reg, ovf_next;
    logic              evt, pop, fifo_full, fifo_empty;
    logic [TS_W-1:0]   fifo_dout;

    // A held-high detector output is one detection.
    assign evt = det_in && !det_q_reg;
    assign pop = !fifo_empty && bus.rd_ready && !clr;

    ts_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_ts_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clr),
        .push  (evt),
        .pop   (pop),
        .din   (ts_reg),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Saturating counter and sticky overflow update.
    always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (clr) begin
            cnt_next = '0;
            ovf_next = 1'b0;
        end else if (evt) begin
            if (cnt_reg != '1)
                cnt_next = cnt_reg + CNT_W'(1);
            if (fifo_full && !pop)
                ovf_next = 1'b1;
        end
    end

    // Edge register, free-running timestamp, counter and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_q_reg <= 1'b0;
            ts_reg    <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            det_q_reg <= det_in;
            ts_reg    <= clr ? '0 : ts_reg + TS_W'(1);
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign bus.rd_valid = !fifo_empty;
    assign bus.rd_data  = fifo_dout;
    assign evt_count    = cnt_reg;
    assign overflow     = ovf_reg;
endmodule

// File: tb/tb_seq_det_event_logger.sv
// Randomised and directed bench for seq_det_event_logger, checked against a
// queue-based reference model of the logger's behaviour.
module tb_seq_det_event_logger;
    import seq_det_pkg::*;

    localparam int DEPTH = DEF_DEPTH;
    localparam int TS_W  = DEF_TS_W;
    localparam int CNT_W = DEF_CNT_W;
    localparam int TSMOD = 1 << TS_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, det_in, clr, rd_ready;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_ts, m_cnt, m_last;
    bit m_ovf, m_prev;
    int m_q[$];

    seq_det_event_logger_if #(.TS_W(TS_W)) bus ();
    assign bus.rd_ready = rd_ready;

    seq_det_event_logger #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .det_in    (det_in),
        .clr       (clr),
        .bus       (bus.master),
        .evt_count (evt_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, then move past the edge.
    task automatic step(input bit d, input bit c, input bit r, input bit s);
        bit ev, pop;
        int sz;
        det_in = d; clr = c; rd_ready = r; rst = s;
        if (s) begin
            m_ts = 0; m_cnt = 0; m_ovf = 0; m_q.delete(); m_prev = 0; m_last = 0;
        end else begin
            ev = d && !m_prev;
            m_prev = d;
            if (c) begin
                m_ts = 0; m_cnt = 0; m_ovf = 0; m_q.delete();
            end else begin
                sz  = m_q.size();
                pop = (sz > 0) && r;
                if (pop) void'(m_q.pop_front());
                if (ev) begin
                    if (sz < DEPTH || pop) m_q.push_back(m_ts);
                    else m_ovf = 1;
                    if (m_cnt < CMAX) m_cnt++;
                end
                m_ts = (m_ts + 1) % TSMOD;
            end
            if (m_q.size() > 0) m_last = m_q[0];
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1);
        step(0, 0, 0, 1);
        n_checks += 4;
        if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", bus.rd_valid); end
        if (bus.rd_data !== '0) begin n_fail++; $display("FAIL reset_data got=%0d exp=0", bus.rd_data); end
        if (evt_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", evt_count); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int got[$];
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            if (bus.rd_valid === 1'b1) got.push_back(int'(bus.rd_data));
            step(k == 5 || k == 9, 0, 1, 0);
        end
        n_checks += 3;
        if (got.size() != 2) begin n_fail++; $display("FAIL basic_pops got=%0d exp=2", got.size()); end
        else begin
            n_checks += 2;
            if (got[0] != 5) begin n_fail++; $display("FAIL basic_first got=%0d exp=5", got[0]); end
            if (got[1] != 9) begin n_fail++; $display("FAIL basic_second got=%0d exp=9", got[1]); end
        end
        if (evt_count !== CNT_W'(2)) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", evt_count); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%0b exp=0", overflow); end
        $display("test_basic popped=%0d count=%0d", got.size(), evt_count);
    endtask

    // Serial stream through a behavioural 10X0 overlapping Moore detector.
    task automatic test_detector();
        bit bits[$] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        bit hist[$];
        bit op, op_prev;
        int exp_ts[$];
        int got[$];
        step(0, 0, 0, 1);
        op_prev = 0;
        for (int k = 0; k < bits.size(); k++) begin
            op = (hist.size() >= 4) && hist[hist.size()-4] && !hist[hist.size()-3] && !hist[hist.size()-1];
            if (op && !op_prev) exp_ts.push_back(k);
            op_prev = op;
            hist.push_back(bits[k]);
            step(op, 0, 0, 0);
        end
        n_checks++;
        if (evt_count !== CNT_W'(exp_ts.size())) begin
            n_fail++; $display("FAIL det_count got=%0d exp=%0d", evt_count, exp_ts.size());
        end
        for (int k = 0; k < 8; k++) begin
            if (bus.rd_valid === 1'b1) got.push_back(int'(bus.rd_data));
            step(0, 0, 1, 0);
        end
        n_checks++;
        if (got.size() != exp_ts.size()) begin n_fail++; $display("FAIL det_entries got=%0d exp=%0d", got.size(), exp_ts.size()); end
        else foreach (got[i]) begin
            n_checks++;
            if (got[i] != exp_ts[i]) begin n_fail++; $display("FAIL det_ts[%0d] got=%0d exp=%0d", i, got[i], exp_ts[i]); end
        end
        $display("test_detector pulses=%0d count=%0d", exp_ts.size(), evt_count);
    endtask

    task automatic test_overflow();
        int got[$];
        step(0, 0, 0, 1);
        for (int k = 0; k < 10; k++) step(k % 2 == 0, 0, 0, 0);
        n_checks += 3;
        if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got=%0b exp=1", bus.rd_valid); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        if (evt_count !== CNT_W'(5)) begin n_fail++; $display("FAIL ovf_count got=%0d exp=5", evt_count); end
        for (int k = 0; k < 10; k++) begin
            if (bus.rd_valid === 1'b1) got.push_back(int'(bus.rd_data));
            step(0, 0, 1, 0);
        end
        n_checks++;
        if (got.size() != 4) begin n_fail++; $display("FAIL ovf_drain got=%0d exp=4", got.size()); end
        else foreach (got[i]) begin
            n_checks++;
            if (got[i] != 2 * i) begin n_fail++; $display("FAIL ovf_ts[%0d] got=%0d exp=%0d", i, got[i], 2 * i); end
        end
        $display("test_overflow drained=%0d", got.size());
    endtask

    task automatic test_full_pop();
        int got[$];
        step(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) step(k % 2 == 0, 0, 0, 0);
        step(1, 0, 1, 0);   // event at ts=8 together with a pop of ts=0
        n_checks += 3;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got=%0b exp=0", overflow); end
        if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL fullpop_valid got=%0b exp=1", bus.rd_valid); end
        if (bus.rd_data !== TS_W'(2)) begin n_fail++; $display("FAIL fullpop_head got=%0d exp=2", bus.rd_data); end
        for (int k = 0; k < 8; k++) begin
            if (bus.rd_valid === 1'b1) got.push_back(int'(bus.rd_data));
            step(0, 0, 1, 0);
        end
        n_checks++;
        if (got.size() != 4) begin n_fail++; $display("FAIL fullpop_occ got=%0d exp=4", got.size()); end
        else foreach (got[i]) begin
            n_checks++;
            if (got[i] != 2 * i + 2) begin n_fail++; $display("FAIL fullpop_ts[%0d] got=%0d exp=%0d", i, got[i], 2 * i + 2); end
        end
        $display("test_full_pop entries=%0d", got.size());
    endtask

    task automatic test_hold_saturate();
        step(0, 0, 0, 1);
        for (int k = 0; k < 6; k++) step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        n_checks++;
        if (evt_count !== CNT_W'(1)) begin n_fail++; $display("FAIL hold_count got=%0d exp=1", evt_count); end
        for (int k = 0; k < 299; k++) begin step(1, 0, 1, 0); step(0, 0, 1, 0); end
        n_checks += 2;
        if (evt_count !== CNT_W'(CMAX)) begin n_fail++; $display("FAIL sat_count got=%0d exp=%0d", evt_count, CMAX); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat_ovf got=%0b exp=0", overflow); end
        $display("test_hold_saturate count=%0d", evt_count);
    endtask

    task automatic test_clr_rst();
        for (int mode = 0; mode < 2; mode++) begin
            step(0, 0, 0, 1);
            for (int k = 0; k < 6; k++) step(k % 2 == 0, 0, 0, 0);
            step(1, mode == 0, 0, mode == 1);
            n_checks += 3;
            if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL clrrst%0d_valid got=%0b exp=0", mode, bus.rd_valid); end
            if (evt_count !== '0) begin n_fail++; $display("FAIL clrrst%0d_count got=%0d exp=0", mode, evt_count); end
            if (overflow !== 1'b0) begin n_fail++; $display("FAIL clrrst%0d_ovf got=%0b exp=0", mode, overflow); end
            step(0, 0, 0, 0);
            step(1, 0, 0, 0);
            n_checks += 2;
            if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL clrrst%0d_after_valid got=%0b exp=1", mode, bus.rd_valid); end
            if (bus.rd_data !== TS_W'(1)) begin n_fail++; $display("FAIL clrrst%0d_ts got=%0d exp=1", mode, bus.rd_data); end
            $display("test_clr_rst mode=%0d data=%0d", mode, bus.rd_data);
        end
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_fail;
        step(0, 0, 0, 1);
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
            n_checks += 4;
            if (bus.rd_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", k, bus.rd_valid, m_q.size() > 0); end
            if (bus.rd_data !== TS_W'(m_last)) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%0d exp=%0d", k, bus.rd_data, m_last); end
            if (evt_count !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", k, evt_count, m_cnt); end
            if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", k, overflow, m_ovf); end
        end
        $display("test_random cycles=1500 new_failures=%0d", n_fail - errs_before);
    endtask

    initial begin
        rst = 1'b1; det_in = 1'b0; clr = 1'b0; rd_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_detector();
        test_overflow();
        test_full_pop();
        test_hold_saturate();
        test_clr_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
